// File: rtl/chimera_pkg.sv
// Shared types and defaults for the Chimera cluster power sequencer.
package chimera_pkg;

  localparam int unsigned ExtClusters      = 2;
  localparam int unsigned CluResetCycles   = 8;
  localparam int unsigned CluSettleCycles  = 4;
  localparam int unsigned CluTimeoutCycles = 1024;

  typedef enum logic [2:0] {
    CLU_OFF     = 3'd0,
    CLU_CLK_ON  = 3'd1,
    CLU_RST_REL = 3'd2,
    CLU_DEISO   = 3'd3,
    CLU_ON      = 3'd4,
    CLU_ISO     = 3'd5,
    CLU_CLK_OFF = 3'd6
  } clu_pwr_state_e;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// Single-cluster power sequencer: state machine plus shared
// down-counter for reset, settle and handshake-timeout phases.
module chimera_clu_pwr_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned ResetCycles   = CluResetCycles,
  parameter int unsigned SettleCycles  = CluSettleCycles,
  parameter int unsigned TimeoutCycles = CluTimeoutCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pwr_req_i,
  input  logic [NumPorts-1:0]  isolated_i,
  input  logic                 timeout_clr_i,
  output logic                 isolate_o,
  output logic                 clk_en_o,
  output logic                 rst_no,
  output clu_pwr_state_e       state_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 done_o
);

  localparam int unsigned CntMax =
    max3(ResetCycles, SettleCycles, TimeoutCycles);
  localparam int unsigned CntW = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  clu_pwr_state_e state_q, state_d;
  cnt_t           cnt_q, cnt_d;
  logic           iso_q, iso_d;
  logic           clk_en_q, clk_en_d;
  logic           rst_n_q, rst_n_d;
  logic           busy_q, busy_d;
  logic           tmo_q, tmo_d;
  logic           done_q, done_d;
  logic           all_iso, none_iso;
  logic           last, tmo_set;

  function automatic cnt_t load_val(input clu_pwr_state_e s);
    unique case (s)
      CLU_CLK_ON,
      CLU_CLK_OFF: return cnt_t'(ResetCycles);
      CLU_RST_REL: return cnt_t'(SettleCycles);
      CLU_DEISO,
      CLU_ISO:     return cnt_t'(TimeoutCycles);
      default:     return '0;
    endcase
  endfunction

  assign all_iso  = &isolated_i;
  assign none_iso = ~|isolated_i;
  assign last     = (cnt_q <= cnt_t'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLU_OFF:     if (pwr_req_i) state_d = CLU_CLK_ON;
      CLU_CLK_ON:  if (last) state_d = CLU_RST_REL;
      CLU_RST_REL: if (last) state_d = CLU_DEISO;
      CLU_DEISO:   if (none_iso) state_d = CLU_ON;
      CLU_ON:      if (!pwr_req_i) state_d = CLU_ISO;
      // abort: a raised request during isolation reverts to DEISO
      CLU_ISO: begin
        if (pwr_req_i)    state_d = CLU_DEISO;
        else if (all_iso) state_d = CLU_CLK_OFF;
      end
      CLU_CLK_OFF: if (last) state_d = CLU_OFF;
      default:     state_d = CLU_OFF;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = load_val(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  // Flag fires on the step that drains the counter while still waiting
  assign tmo_set = (state_q inside {CLU_DEISO, CLU_ISO}) &&
                   (state_d == state_q) &&
                   (cnt_q == cnt_t'(1));

  always_comb begin
    tmo_d    = tmo_set | (tmo_q & ~timeout_clr_i);
    done_d   = (state_d != state_q) &&
               (state_d inside {CLU_ON, CLU_OFF});
    iso_d    = !(state_d inside {CLU_DEISO, CLU_ON});
    clk_en_d = (state_d != CLU_OFF);
    rst_n_d  = state_d inside
               {CLU_RST_REL, CLU_DEISO, CLU_ON, CLU_ISO};
    busy_d   = !(state_d inside {CLU_OFF, CLU_ON});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CLU_OFF;
      cnt_q    <= '0;
      iso_q    <= 1'b1;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iso_q    <= iso_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
    end
  end

  assign isolate_o = iso_q;
  assign clk_en_o  = clk_en_q;
  assign rst_no    = rst_n_q;
  assign state_o   = state_q;
  assign busy_o    = busy_q;
  assign timeout_o = tmo_q;
  assign done_o    = done_q;

endmodule

// File: rtl/chimera_clu_pwr_ctrl.sv
// Per-cluster power sequencer array for the Chimera cluster domain;
// one independent FSM per cluster, outputs concatenated.
module chimera_clu_pwr_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters   = ExtClusters,
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned ResetCycles   = CluResetCycles,
  parameter int unsigned SettleCycles  = CluSettleCycles,
  parameter int unsigned TimeoutCycles = CluTimeoutCycles
) (
  input  logic                            soc_clk_i,
  input  logic                            rst_ni,
  input  logic [NumClusters-1:0]          pwr_req_i,
  input  logic [NumClusters*NumPorts-1:0] isolated_i,
  output logic [NumClusters-1:0]          isolate_o,
  output logic [NumClusters-1:0]          clu_clk_en_o,
  output logic [NumClusters-1:0]          clu_rst_no,
  output logic [NumClusters*3-1:0]        state_o,
  output logic [NumClusters-1:0]          busy_o,
  output logic [NumClusters-1:0]          timeout_o,
  input  logic [NumClusters-1:0]          timeout_clr_i,
  output logic [NumClusters-1:0]          done_o
);

  for (genvar i = 0; i < NumClusters; i++) begin : gen_clu
    clu_pwr_state_e st;

    chimera_clu_pwr_fsm #(
      .NumPorts      (NumPorts),
      .ResetCycles   (ResetCycles),
      .SettleCycles  (SettleCycles),
      .TimeoutCycles (TimeoutCycles)
    ) i_fsm (
      .clk_i         (soc_clk_i),
      .rst_ni        (rst_ni),
      .pwr_req_i     (pwr_req_i[i]),
      .isolated_i    (isolated_i[i*NumPorts +: NumPorts]),
      .timeout_clr_i (timeout_clr_i[i]),
      .isolate_o     (isolate_o[i]),
      .clk_en_o      (clu_clk_en_o[i]),
      .rst_no        (clu_rst_no[i]),
      .state_o       (st),
      .busy_o        (busy_o[i]),
      .timeout_o     (timeout_o[i]),
      .done_o        (done_o[i])
    );

    assign state_o[i*3 +: 3] = st;
  end

endmodule

// File: tb/tb_chimera_clu_pwr_ctrl.sv
// Scoreboard bench: stimulus tasks schedule expected output edges,
// a negedge monitor pops and compares every observed change.
module tb_chimera_clu_pwr_ctrl;

  localparam int NC = 2;
  localparam int NP = 4;
  localparam int R  = 8;
  localparam int S  = 4;
  localparam int T  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NC-1:0]        req = '0;
  logic [NC-1:0]        clr = '0;
  logic [NC*NP-1:0]     iso_in = '1;
  logic [NC-1:0]        isolate_o, clk_en_o, rst_no;
  logic [NC-1:0]        busy_o, timeout_o, done_o;
  logic [NC*3-1:0]      state_o;

  chimera_clu_pwr_ctrl #(
    .NumClusters   (NC),
    .NumPorts      (NP),
    .ResetCycles   (R),
    .SettleCycles  (S),
    .TimeoutCycles (T)
  ) dut (
    .soc_clk_i     (clk),
    .rst_ni        (rst_n),
    .pwr_req_i     (req),
    .isolated_i    (iso_in),
    .isolate_o     (isolate_o),
    .clu_clk_en_o  (clk_en_o),
    .clu_rst_no    (rst_no),
    .state_o       (state_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .timeout_clr_i (clr),
    .done_o        (done_o)
  );

  // state codes: OFF0 CLK_ON1 RST_REL2 DEISO3 ON4 ISO5 CLK_OFF6
  typedef struct {
    int cyc;
    int sig;
    int val;
  } ev_t;

  ev_t   q[NC][$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  int    prev[NC][7];
  bit    mon_en = 0;
  bit    drain = 0;
  bit    drained = 0;
  string nm[7] = '{"isolate", "clk_en", "rst_n", "busy",
                   "done", "timeout", "state"};
  int    rv[7] = '{1, 0, 0, 0, 0, 0, 0};

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic int get(input int c, input int s);
    case (s)
      0:       return int'(isolate_o[c]);
      1:       return int'(clk_en_o[c]);
      2:       return int'(rst_no[c]);
      3:       return int'(busy_o[c]);
      4:       return int'(done_o[c]);
      5:       return int'(timeout_o[c]);
      default: return int'(state_o[c*3 +: 3]);
    endcase
  endfunction

  task automatic push(input int c, input int t,
                      input int s, input int v);
    ev_t e;
    int  i;
    e = '{t, s, v};
    i = 0;
    while (i < q[c].size() &&
           (q[c][i].cyc * 8 + q[c][i].sig) <= t * 8 + s)
      i++;
    q[c].insert(i, e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ports(input int c, input logic v);
    for (int p = 0; p < NP; p++) iso_in[c*NP+p] = v;
  endtask

  // Isolation phase starting at cycle a; pd<0 marks a port that never isolates
  task automatic down_body(input int c, input int a,
                           input int pd[NP]);
    int m, y, z;
    bit stuck;
    m = 0;
    stuck = 0;
    for (int p = 0; p < NP; p++) begin
      if (pd[p] < 0) stuck = 1;
      else if (pd[p] > m) m = pd[p];
    end
    push(c, a, 0, 1);
    push(c, a, 3, 1);
    push(c, a, 6, 5);
    if (stuck || m >= T) push(c, a + T, 5, 1);
    y = a + m + 1;
    z = y + R;
    if (!stuck) begin
      push(c, y, 2, 0);
      push(c, y, 6, 6);
      push(c, z, 1, 0);
      push(c, z, 3, 0);
      push(c, z, 4, 1);
      push(c, z, 6, 0);
      push(c, z + 1, 4, 0);
    end
    for (int k = 0; k <= m; k++) begin
      wait_until(a + k);
      for (int p = 0; p < NP; p++)
        if (pd[p] == k) iso_in[c*NP+p] = 1'b1;
    end
    if (!stuck) wait_until(z + 1);
  endtask

  task automatic down(input int c, input int pd[NP]);
    req[c] = 1'b0;
    down_body(c, cyc + 1, pd);
  endtask

  // Power-up with ports clearing d cycles after the isolation drop;
  // early drops the request while the clock is coming up.
  task automatic up(input int c, input int d, input bit early);
    int a, e, x;
    int pd[NP];
    a = cyc + 1;
    req[c] = 1'b1;
    push(c, a, 1, 1);
    push(c, a, 3, 1);
    push(c, a, 6, 1);
    push(c, a + R, 2, 1);
    push(c, a + R, 6, 2);
    e = a + R + S;
    push(c, e, 0, 0);
    push(c, e, 6, 3);
    x = e + d + 1;
    push(c, x, 3, 0);
    push(c, x, 4, 1);
    push(c, x, 6, 4);
    push(c, x + 1, 4, 0);
    if (early) begin
      wait_until(a + 2);
      req[c] = 1'b0;
    end
    wait_until(e + d);
    set_ports(c, 1'b0);
    wait_until(x);
    if (early) begin
      foreach (pd[p]) pd[p] = int'($urandom_range(9, 0));
      down_body(c, x + 1, pd);
    end
  endtask

  task automatic abort_up(input int c, input int d);
    int e, x;
    req[c] = 1'b1;
    e = cyc + 1;
    push(c, e, 0, 0);
    push(c, e, 6, 3);
    x = e + d + 1;
    push(c, x, 3, 0);
    push(c, x, 4, 1);
    push(c, x, 6, 4);
    push(c, x + 1, 4, 0);
    wait_until(e + d);
    set_ports(c, 1'b0);
    wait_until(x + 3);
    clr[c] = 1'b1;
    push(c, x + 4, 5, 0);
    wait_until(x + 4);
    clr[c] = 1'b0;
  endtask

  task automatic seq(input int c);
    int  pd[NP];
    bit  early;
    wait_until(cyc + int'($urandom_range(3, 0)));
    early = ($urandom_range(3, 0) == 0);
    up(c, int'($urandom_range(6, 0)), early);
    if (!early) begin
      foreach (pd[p]) pd[p] = int'($urandom_range(9, 0));
      down(c, pd);
    end
  endtask

  initial begin
    int ev_v;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int c = 0; c < NC; c++)
          for (int s = 0; s < 7; s++) begin
            vectors++;
            if (get(c, s) != rv[s]) begin
              miscompares++;
              $display("FAIL reset clu%0d %s: got %0d want %0d",
                       c, nm[s], get(c, s), rv[s]);
            end
            prev[c][s] = rv[s];
          end
      end else if (drain && !drained) begin
        for (int c = 0; c < NC; c++)
          while (q[c].size() != 0) begin
            e = q[c].pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing clu%0d %s: never saw %0d at cycle %0d",
                     c, nm[e.sig], e.val, e.cyc);
          end
        drained = 1;
      end else if (mon_en) begin
        for (int c = 0; c < NC; c++)
          for (int s = 0; s < 7; s++) begin
            ev_v = get(c, s);
            if (ev_v != prev[c][s]) begin
              prev[c][s] = ev_v;
              vectors++;
              if (q[c].size() == 0) begin
                miscompares++;
                $display("FAIL unexpected clu%0d %s: got %0d at cycle %0d",
                         c, nm[s], ev_v, cyc);
              end else begin
                e = q[c].pop_front();
                if (e.cyc != cyc || e.sig != s || e.val != ev_v) begin
                  miscompares++;
                  $display("FAIL clu%0d %s: got %0d at cycle %0d, want %s=%0d at cycle %0d",
                           c, nm[s], ev_v, cyc, nm[e.sig], e.val, e.cyc);
                end
              end
            end
          end
      end
    end
  end

  initial begin
    int pd[NP];
    int a;
    wait_until(3);
    rst_n = 1'b1;
    mon_en = 1;
    wait_until(cyc + 2);

    up(0, 2, 0);
    pd = '{1, 3, 5, 7};
    down(0, pd);
    wait_until(cyc + 2);

    up(0, 1, 0);
    pd = '{2, 4, 6, -1};
    req[0] = 1'b0;
    a = cyc + 1;
    down_body(0, a, pd);
    wait_until(a + T + 3);
    abort_up(0, 3);
    pd = '{0, 2, 1, 3};
    down(0, pd);
    wait_until(cyc + 2);

    up(0, 2, 1);
    wait_until(cyc + 2);

    up(1, 3, 0);
    pd = '{4, 1, 2, 6};
    fork
      up(0, 1, 0);
      down(1, pd);
    join
    pd = '{3, 3, 0, 5};
    down(0, pd);
    wait_until(cyc + 2);

    for (int it = 0; it < 6; it++) begin
      fork
        seq(0);
        seq(1);
      join
    end
    wait_until(cyc + 2);

    req[0] = 1'b1;
    a = cyc + 1;
    push(0, a, 1, 1);
    push(0, a, 3, 1);
    push(0, a, 6, 1);
    wait_until(a + 3);
    rst_n = 1'b0;
    req[0] = 1'b0;
    wait_until(cyc + 2);
    rst_n = 1'b1;
    wait_until(cyc + 4);

    drain = 1;
    for (int i = 0; i < 10 && !drained; i++) @(posedge clk);
    if (!drained) begin
      $display("FAIL drain: monitor never completed final check");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
